// File: rtl/prienc_lsb.sv
// prienc_lsb: registered LSB-priority encoder.
// The lowest-numbered set bit of req wins. The winning index and an
// any-request flag are registered, so results appear one cycle after the
// request is sampled. A new request is accepted every cycle.
module prienc_lsb #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  req,
  output logic [OUT_WIDTH-1:0] prior_out,
  output logic                 valid
);

  // The tree works on a power-of-two number of leaves. Leaves beyond
  // IN_WIDTH are tied to "no request", so they can never win.
  localparam int LEVELS = OUT_WIDTH;
  localparam int LEAVES = 1 << LEVELS;

  logic                 root_valid;
  logic [OUT_WIDTH-1:0] root_index;

  // Each stage halves the node count. A node is valid when either child is
  // valid, and it carries the left (lower-numbered) child's index whenever
  // the left child is valid. Depth grows with log2 of the width.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : stage
    localparam int NODES = LEAVES >> lv;

    logic [NODES-1:0]     node_valid;
    logic [OUT_WIDTH-1:0] node_index [NODES];

    if (lv == 0) begin : leaf
      for (genvar n = 0; n < NODES; n++) begin : node
        if (n < IN_WIDTH) begin : used
          assign node_valid[n] = req[n];
        end else begin : pad
          assign node_valid[n] = 1'b0;
        end
        assign node_index[n] = OUT_WIDTH'(n);
      end
    end else begin : merge
      for (genvar n = 0; n < NODES; n++) begin : node
        assign node_valid[n] = stage[lv-1].node_valid[2*n] |
                               stage[lv-1].node_valid[2*n+1];
        assign node_index[n] = stage[lv-1].node_valid[2*n] ?
                               stage[lv-1].node_index[2*n] :
                               stage[lv-1].node_index[2*n+1];
      end
    end
  end

  assign root_valid = stage[LEVELS].node_valid[0];
  assign root_index = stage[LEVELS].node_index[0];

  // Register the result; an empty request (or reset) yields index 0, flag 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prior_out <= '0;
      valid     <= 1'b0;
    end else begin
      valid     <= root_valid;
      prior_out <= root_valid ? root_index : '0;
    end
  end

endmodule

// File: tb/tb_prienc_lsb.sv
// tb_prienc_lsb: directed and random checks of the registered LSB-priority
// encoder with hand-computed expected values and a loop-based reference.
module tb_prienc_lsb;

  localparam int W  = 128;
  localparam int OW = $clog2(W);

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  req;
  logic [OW-1:0] prior_out;
  logic          valid;

  int compared;
  int mismatched;

  prienc_lsb #(.IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .prior_out (prior_out),
    .valid     (valid)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: scan from bit 0 upward, first set bit wins, 0 if none.
  function automatic int lowest_idx(input logic [W-1:0] r);
    for (int i = 0; i < W; i++) begin
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // Drive inputs on the falling edge, then wait past the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] r, input logic rn);
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  // Compare both outputs against expected values.
  task automatic checkOutput(input string tag, input int exp_idx, input logic exp_v);
    logic [OW-1:0] exp_p;
    exp_p = OW'(exp_idx);
    compared++;
    assert (prior_out === exp_p) else begin
      mismatched++;
      $error("[TB] FAIL %s prior_out=%0d expected %0d", tag, prior_out, exp_p);
    end
    compared++;
    assert (valid === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s valid=%0b expected %0b", tag, valid, exp_v);
    end
  endtask

  logic [W-1:0] one;
  logic [W-1:0] ones;
  logic [W-1:0] r;

  initial begin
    compared   = 0;
    mismatched = 0;
    one        = {{(W-1){1'b0}}, 1'b1};
    ones       = '1;
    req        = ones;
    rst_n      = 1'b0;

    // Reset held for two edges with every request line set.
    applyStimulus(ones, 1'b0);
    checkOutput("reset_edge1", 0, 1'b0);
    applyStimulus(ones, 1'b0);
    checkOutput("reset_edge2", 0, 1'b0);

    // Empty request after reset.
    applyStimulus('0, 1'b1);
    checkOutput("zero_req", 0, 1'b0);

    // Walking one across every line, including the top line.
    for (int i = 0; i < W; i++) begin
      applyStimulus(one << i, 1'b1);
      checkOutput($sformatf("walk_%0d", i), i, 1'b1);
    end

    // Multi-bit patterns: lower set bits must win.
    applyStimulus(W'(8'hA8), 1'b1);
    checkOutput("multi_a8", 3, 1'b1);
    applyStimulus((one << 127) | (one << 64), 1'b1);
    checkOutput("multi_127_64", 64, 1'b1);
    applyStimulus(ones, 1'b1);
    checkOutput("all_ones", 0, 1'b1);

    // Reset must not act between clock edges: outputs hold after rst_n drops.
    applyStimulus(one << 9, 1'b1);
    checkOutput("pre_async", 9, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("no_async_reset", 9, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("sync_reset_edge", 0, 1'b0);

    // Walking one with a single-edge reset at i=40.
    for (int i = 0; i < 48; i++) begin
      applyStimulus(one << i, (i != 40));
      if (i == 40) checkOutput("midreset_40", 0, 1'b0);
      else         checkOutput($sformatf("midwalk_%0d", i), i, 1'b1);
    end

    // Random 32-bit values zero-extended to the full width.
    for (int k = 0; k < 100; k++) begin
      r = W'($urandom());
      applyStimulus(r, 1'b1);
      checkOutput($sformatf("rand_%0d", k), lowest_idx(r), (r != '0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the stimulus sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout compared=%0d expected completion", compared);
    $fatal(1, "[TB] timeout");
  end

endmodule
